// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared constants and helpers for the EX stage
// Purpose: ALU op codes, forward-select codes, branch funct3 codes, writeback
//          select codes and the operand forwarding mux helper.
// Ports:   none (package)
// Option:  EXEC_SHIFT_EN enables the shift ops (ALU_SLL/ALU_SRL/ALU_SRA) in the ALU.
package execute_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Select code 2'b11 is unused by the hazard unit and falls back to the register value.
  function automatic logic [XLEN-1:0] fwdMux(input logic [1:0] sel,
                                             input logic [XLEN-1:0] regVal,
                                             input logic [XLEN-1:0] wbVal,
                                             input logic [XLEN-1:0] memVal);
    case (sel)
      FWD_WB:  return wbVal;
      FWD_MEM: return memVal;
      default: return regVal;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX inputs, forwarding inputs and EX/MEM outputs of the EX stage
// Purpose: bundles every non-clock/reset signal of execute_stage.
// Ports:   master = upstream/driver side (drives ID/EX, forwarding, flushM; observes results)
//          slave  = execute_stage side (consumes ID/EX; drives pcselE/pc_targetE and EX/MEM)
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic            regwriteE, memrwE, brunE, branchE, jumpE, bselE;
  logic [1:0]      wbselE;
  logic [2:0]      ALUselE, funct3E;
  logic [4:0]      rdE;
  logic [XLEN-1:0] rd1E, rd2E, imm_exE, pcE, pc4E;
  logic [1:0]      forwardAE, forwardBE;
  logic [XLEN-1:0] resultW;
  logic            flushM;

  logic            pcselE;
  logic [XLEN-1:0] pc_targetE;
  logic            regwriteM, memrwM;
  logic [1:0]      wbselM;
  logic [2:0]      funct3M;
  logic [4:0]      rdM;
  logic [XLEN-1:0] alu_resultM, write_dataM, pc4M;

  modport master (
    output regwriteE, memrwE, brunE, branchE, jumpE, bselE, wbselE, ALUselE, funct3E,
           rdE, rd1E, rd2E, imm_exE, pcE, pc4E, forwardAE, forwardBE, resultW, flushM,
    input  pcselE, pc_targetE, regwriteM, memrwM, wbselM, funct3M, rdM,
           alu_resultM, write_dataM, pc4M
  );

  modport slave (
    input  regwriteE, memrwE, brunE, branchE, jumpE, bselE, wbselE, ALUselE, funct3E,
           rdE, rd1E, rd2E, imm_exE, pcE, pc4E, forwardAE, forwardBE, resultW, flushM,
    output pcselE, pc_targetE, regwriteM, memrwM, wbselM, funct3M, rdM,
           alu_resultM, write_dataM, pc4M
  );

endinterface

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational ALU for the EX stage
// Purpose: add/sub/and/or/xor; with EXEC_SHIFT_EN also sll/srl/sra by b[4:0].
//          Without EXEC_SHIFT_EN codes 101-111 return 0 and no shifter exists.
// Ports:   a, b (operands), aluSel (op code) -> result
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      aluSel,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (aluSel)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
`ifdef EXEC_SHIFT_EN
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - pipeline EX stage: forwarding, ALU, branch/jump resolve, EX/MEM register
// Purpose: forwards operands, computes the ALU result, resolves the PC redirect
//          combinationally and registers results into EX/MEM every cycle.
// Ports:   clk (rising edge), rst (async, active-high),
//          bus (execute_stage_if.slave): ID/EX inputs, forwardAE/BE, resultW, flushM in;
//          pcselE/pc_targetE (combinational) and EX/MEM registered outputs out.
// Option:  EXEC_SHIFT_EN (shift ops in the ALU).
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  logic [DATA_W-1:0] srcA, fwdB, srcB, aluResult;
  logic              ltSigned, ltUnsigned, lessThan, taken;

  assign srcA = fwdMux(bus.forwardAE, bus.rd1E, bus.resultW, bus.alu_resultM);
  assign fwdB = fwdMux(bus.forwardBE, bus.rd2E, bus.resultW, bus.alu_resultM);
  assign srcB = bus.bselE ? bus.imm_exE : fwdB;

  execute_stage_alu uAlu (
    .a      (srcA),
    .b      (srcB),
    .aluSel (bus.ALUselE),
    .result (aluResult)
  );

  // Compare always uses the register operand path (fwdB), never the immediate.
  assign ltUnsigned = srcA < fwdB;
  assign ltSigned   = $signed(srcA) < $signed(fwdB);
  assign lessThan   = bus.brunE ? ltUnsigned : ltSigned;

  always_comb begin
    taken = 1'b0;
    case (bus.funct3E)
      BR_EQ:   taken = (srcA == fwdB);
      BR_NE:   taken = (srcA != fwdB);
      BR_LT:   taken = lessThan;
      BR_GE:   taken = !lessThan;
      BR_LTU:  taken = ltUnsigned;
      BR_GEU:  taken = !ltUnsigned;
      default: taken = 1'b0;
    endcase
  end

  assign bus.pcselE     = bus.jumpE | (bus.branchE & taken);
  // jalr target comes from the ALU (rs1 + imm) with bit 0 cleared.
  assign bus.pc_targetE = (bus.jumpE & bus.bselE) ? {aluResult[DATA_W-1:1], 1'b0}
                                                  : bus.pcE + bus.imm_exE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flushM) begin
      bus.regwriteM   <= 1'b0;
      bus.memrwM      <= 1'b0;
      bus.wbselM      <= 2'b00;
      bus.funct3M     <= 3'b000;
      bus.rdM         <= 5'd0;
      bus.alu_resultM <= '0;
      bus.write_dataM <= '0;
      bus.pc4M        <= '0;
    end else begin
      bus.regwriteM   <= bus.regwriteE;
      bus.memrwM      <= bus.memrwE;
      bus.wbselM      <= bus.wbselE;
      bus.funct3M     <= bus.funct3E;
      bus.rdM         <= bus.rdE;
      bus.alu_resultM <= aluResult;
      bus.write_dataM <= fwdB;
      bus.pc4M        <= bus.pc4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage (directed + random vs model)
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_if bus();

  execute_stage #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errCount = 0;
  int checkCount = 0;

  typedef struct packed {
    logic        regwrite;
    logic        memrw;
    logic [1:0]  wbsel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } exMemT;

  exMemT expM = '0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkVal({tag, " regwriteM"},   32'(bus.regwriteM), 32'(expM.regwrite));
    checkVal({tag, " memrwM"},      32'(bus.memrwM),    32'(expM.memrw));
    checkVal({tag, " wbselM"},      32'(bus.wbselM),    32'(expM.wbsel));
    checkVal({tag, " funct3M"},     32'(bus.funct3M),   32'(expM.funct3));
    checkVal({tag, " rdM"},         32'(bus.rdM),       32'(expM.rd));
    checkVal({tag, " alu_resultM"}, bus.alu_resultM,    expM.alu);
    checkVal({tag, " write_dataM"}, bus.write_dataM,    expM.wd);
    checkVal({tag, " pc4M"},        bus.pc4M,           expM.pc4);
  endtask

  // Reference model: plain arithmetic on the specified rules.
  function automatic logic [31:0] mAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
`ifdef EXEC_SHIFT_EN
      3'd5: return a << sh;
      3'd6: return a >> sh;
      3'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic mTaken(input logic [2:0] f3, input logic brun, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint ua, ub;
    logic lt;
    sa = a; sb = b;
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    lt = (brun || f3[1]) ? (ua < ub) : (sa < sb);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mFwd(input logic [1:0] code, input logic [31:0] regVal);
    if (code == 2'd1) return bus.resultW;
    if (code == 2'd2) return expM.alu;
    return regVal;
  endfunction

  task automatic setDefaults();
    bus.regwriteE = 0; bus.memrwE = 0; bus.brunE = 0; bus.branchE = 0; bus.jumpE = 0;
    bus.bselE = 0; bus.wbselE = 2'b00; bus.ALUselE = 3'b000; bus.funct3E = 3'b010;
    bus.rdE = 5'd0; bus.rd1E = 0; bus.rd2E = 0; bus.imm_exE = 0; bus.pcE = 0; bus.pc4E = 0;
    bus.forwardAE = 2'b00; bus.forwardBE = 2'b00; bus.resultW = 0; bus.flushM = 0;
  endtask

  // Checks the combinational redirect, clocks one edge and checks EX/MEM.
  task automatic runCycle(input string tag);
    logic [31:0] a, fb, sb, alu, tgt;
    logic psel;
    exMemT nxt;
    a   = mFwd(bus.forwardAE, bus.rd1E);
    fb  = mFwd(bus.forwardBE, bus.rd2E);
    sb  = bus.bselE ? bus.imm_exE : fb;
    alu = mAlu(bus.ALUselE, a, sb);
    psel = bus.jumpE || (bus.branchE && mTaken(bus.funct3E, bus.brunE, a, fb));
    tgt  = (bus.jumpE && bus.bselE) ? (alu & 32'hFFFF_FFFE) : bus.pcE + bus.imm_exE;
    #1;
    checkVal({tag, " pcselE"}, 32'(bus.pcselE), 32'(psel));
    checkVal({tag, " pc_targetE"}, bus.pc_targetE, tgt);
    if (bus.flushM) nxt = '0;
    else nxt = '{regwrite: bus.regwriteE, memrw: bus.memrwE, wbsel: bus.wbselE,
                 funct3: bus.funct3E, rd: bus.rdE, alu: alu, wd: fb, pc4: bus.pc4E};
    @(posedge clk);
    #1;
    expM = nxt;
    checkRegs(tag);
  endtask

  initial begin
    setDefaults();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkRegs("reset");
    rst = 1'b0;

    // add
    bus.rd1E = 5; bus.rd2E = 7; bus.regwriteE = 1; bus.wbselE = WB_ALU; bus.rdE = 5'd3;
    runCycle("add");
    checkVal("add lit alu", bus.alu_resultM, 32'd12);
    checkVal("add lit regwrite", 32'(bus.regwriteM), 32'd1);
    checkVal("add lit wbsel", 32'(bus.wbselM), 32'd1);

    // forwarding from MEM and WB
    bus.rd1E = 32'h10; bus.rd2E = 0;
    runCycle("fwd setup");
    bus.rd1E = 32'h999; bus.rd2E = 32'h777;
    bus.forwardAE = FWD_MEM; bus.forwardBE = FWD_WB; bus.resultW = 3; bus.ALUselE = ALU_SUB;
    runCycle("fwd");
    checkVal("fwd lit alu", bus.alu_resultM, 32'h0D);

    // blt signed vs unsigned
    setDefaults();
    bus.rd1E = 32'hFFFF_FFFF; bus.rd2E = 1; bus.branchE = 1; bus.funct3E = BR_LT;
    bus.pcE = 32'h40; bus.imm_exE = 32'h10;
    #1;
    checkVal("blt lit pcsel", 32'(bus.pcselE), 32'd1);
    checkVal("blt lit target", bus.pc_targetE, 32'h50);
    runCycle("blt");
    bus.brunE = 1;
    #1;
    checkVal("bltu lit pcsel", 32'(bus.pcselE), 32'd0);
    runCycle("bltu");

    // jalr
    setDefaults();
    bus.rd1E = 32'h103; bus.imm_exE = 4; bus.jumpE = 1; bus.bselE = 1;
    bus.pc4E = 32'h208; bus.wbselE = WB_PC4; bus.regwriteE = 1; bus.rdE = 5'd1;
    #1;
    checkVal("jalr lit target", bus.pc_targetE, 32'h106);
    checkVal("jalr lit pcsel", 32'(bus.pcselE), 32'd1);
    runCycle("jalr");
    checkVal("jalr lit pc4M", bus.pc4M, 32'h208);
    checkVal("jalr lit wbselM", 32'(bus.wbselM), 32'd2);

    // store data forwarding, then flush on the same inputs
    setDefaults();
    bus.memrwE = 1; bus.forwardBE = FWD_WB; bus.resultW = 32'hDEAD; bus.rd2E = 32'h1234;
    bus.bselE = 1; bus.imm_exE = 8; bus.rd1E = 32'h100; bus.funct3E = 3'b010;
    runCycle("sw");
    checkVal("sw lit write_data", bus.write_dataM, 32'hDEAD);
    bus.flushM = 1;
    runCycle("flush");
    checkVal("flush lit alu", bus.alu_resultM, 32'h0);

    // asynchronous reset between edges
    setDefaults();
    bus.rd1E = 32'h55; bus.rd2E = 32'h22; bus.regwriteE = 1; bus.rdE = 5'd9; bus.pc4E = 32'h44;
    runCycle("pre-rst");
    #3 rst = 1'b1;
    #1;
    expM = '0;
    checkRegs("async rst");
    #1 rst = 1'b0;

`ifdef EXEC_SHIFT_EN
    setDefaults();
    bus.rd1E = 32'h8000_0000; bus.rd2E = 4; bus.ALUselE = ALU_SRA;
    runCycle("sra");
    checkVal("sra lit", bus.alu_resultM, 32'hF800_0000);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.regwriteE = 1'($urandom);
      bus.memrwE    = 1'($urandom);
      bus.brunE     = 1'($urandom);
      bus.branchE   = 1'($urandom);
      bus.jumpE     = ($urandom_range(0, 3) == 0);
      bus.bselE     = 1'($urandom);
      bus.wbselE    = 2'($urandom_range(0, 2));
      bus.ALUselE   = 3'($urandom);
      bus.funct3E   = 3'($urandom);
      bus.rdE       = 5'($urandom);
      bus.rd1E      = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.rd2E      = ($urandom_range(0, 3) == 0) ? bus.rd1E : $urandom;
      bus.imm_exE   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      bus.pcE       = $urandom & 32'hFFFF_FFFC;
      bus.pc4E      = bus.pcE + 4;
      bus.forwardAE = 2'($urandom);
      bus.forwardBE = 2'($urandom);
      bus.resultW   = $urandom;
      bus.flushM    = ($urandom_range(0, 7) == 0);
      runCycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
